// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, IR field positions and feeder state encoding shared by the CPU blocks
package cpu_pkg;
  localparam int DATA_W = 9;
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MV  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MVI = 3'b100;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_I  = 3'd1;
  localparam logic [2:0] S_LAT_I = 3'd2;
  localparam logic [2:0] S_RD_D  = 3'd3;
  localparam logic [2:0] S_LAT_D = 3'd4;
  localparam logic [2:0] S_EXEC0 = 3'd5;
  localparam logic [2:0] S_EXEC  = 3'd6;
  function automatic logic [2:0] op_of(input logic [8:0] w);
    return w[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/feeder_watchdog.sv
// feeder_watchdog: counts EXEC cycles and flags a timeout when done never arrives
module feeder_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] cnt_q;
  assign timeout = en && cnt_q == LAST;
  // count enabled cycles since the last clear, parking at the timeout value
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en && !timeout) cnt_q <= cnt_q + ONE;
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: fetches program words and feeds din/run to the control unit until halt or error
module instr_feeder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9,
  parameter int TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        instr_count
);
  localparam logic [ADDR_W:0] PC_ONE = 1;
  localparam logic [ADDR_W:0] PC_TWO = 2;
  logic [2:0] st_q, st_d;
  logic [ADDR_W:0] pc_q, pc_d, len_q, len_d, pc_inc, addr_full;
  logic [DATA_W-1:0] ir_q, ir_d, imm_q, imm_d, din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] cnt_q, cnt_d;
  logic stop_q, stop_d, halted_q, halted_d, error_q, error_d;
  logic run_q, run_d, rd_q, rd_d, is_mvi, timeout;
  logic [2:0] op_rd;
  assign mem_addr = addr_q;
  assign mem_rd = rd_q;
  assign din = din_q;
  assign run = run_q;
  assign busy = st_q != S_IDLE;
  assign halted = halted_q;
  assign error = error_q;
  assign instr_count = cnt_q;
  assign is_mvi = op_of(ir_q) == OP_MVI;
  assign pc_inc = pc_q + (is_mvi ? PC_TWO : PC_ONE);
  assign op_rd = op_of(mem_rdata);
  feeder_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock(clock),
    .resetn(resetn),
    .clr(st_q == S_EXEC0),
    .en(st_q == S_EXEC),
    .timeout(timeout)
  );
  // sequencing: fetch, decode, optional immediate fetch, issue and wait for done
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    len_d = len_q;
    ir_d = ir_q;
    imm_d = imm_q;
    cnt_d = cnt_q;
    halted_d = halted_q;
    error_d = error_q;
    stop_d = stop_q | (stop & (st_q != S_IDLE));
    case (st_q)
      S_IDLE: if (start) begin
        pc_d = '0;
        len_d = prog_len;
        cnt_d = '0;
        error_d = 1'b0;
        halted_d = prog_len == '0;
        st_d = prog_len == '0 ? S_IDLE : S_RD_I;
      end
      S_RD_I: st_d = S_LAT_I;
      S_LAT_I: begin
        ir_d = mem_rdata;
        error_d = op_rd > OP_MVI || (op_rd == OP_MVI && pc_q + PC_ONE >= len_q);
        st_d = error_d ? S_IDLE : op_rd == OP_MVI ? S_RD_D : S_EXEC0;
      end
      S_RD_D: st_d = S_LAT_D;
      S_LAT_D: begin
        imm_d = mem_rdata;
        st_d = S_EXEC0;
      end
      S_EXEC0: st_d = S_EXEC;
      S_EXEC: if (done) begin
        pc_d = pc_inc;
        cnt_d = cnt_q == 8'd255 ? cnt_q : cnt_q + 8'd1;
        halted_d = pc_inc >= len_q || stop_q || stop;
        st_d = halted_d ? S_IDLE : S_RD_I;
      end else if (timeout) begin
        error_d = 1'b1;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    stop_d = st_d == S_IDLE ? 1'b0 : stop_d;
    run_d = st_d == S_EXEC0 || st_d == S_EXEC;
    din_d = st_d == S_EXEC0 ? ir_d : st_d == S_EXEC ? (is_mvi ? imm_q : ir_q) : '0;
    rd_d = st_d == S_RD_I || st_d == S_RD_D;
    addr_full = st_d == S_RD_D ? pc_d + PC_ONE : pc_d;
    addr_d = addr_full[ADDR_W-1:0];
  end
  // state and registered outputs; reset drops run and din at once
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      st_q <= S_IDLE;
      pc_q <= '0;
      len_q <= '0;
      ir_q <= '0;
      imm_q <= '0;
      cnt_q <= '0;
      halted_q <= 1'b0;
      error_q <= 1'b0;
      stop_q <= 1'b0;
      run_q <= 1'b0;
      din_q <= '0;
      rd_q <= 1'b0;
      addr_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      len_q <= len_d;
      ir_q <= ir_d;
      imm_q <= imm_d;
      cnt_q <= cnt_d;
      halted_q <= halted_d;
      error_q <= error_d;
      stop_q <= stop_d;
      run_q <= run_d;
      din_q <= din_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
    end
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: directed scenarios against a program memory and control-unit responder
module tb_instr_feeder;
  logic clock = 1'b0;
  logic resetn, start, stop, mem_rd, run, done, busy, halted, error, no_done;
  logic [5:0] prog_len;
  logic [4:0] mem_addr;
  logic [8:0] mem_rdata, din;
  logic [7:0] instr_count;
  logic [8:0] mem [32];
  logic [3:0] cu_cnt;
  logic [2:0] cu_op;
  logic [3:0] need;
  int checks = 0;
  int errors = 0;

  instr_feeder dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .prog_len(prog_len),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .din(din), .run(run),
    .done(done), .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

  // control-unit model: step counter runs while run is high, done on the opcode's final step
  always @(posedge clock) begin
    cu_cnt <= run ? cu_cnt + 4'd1 : 4'd0;
    if (run && cu_cnt == 4'd0) cu_op <= din[8:6];
  end
  assign need = cu_op == 3'b000 ? 4'd1 : cu_op == 3'b001 ? 4'd2 : cu_op == 3'b100 ? 4'd2 : 4'd3;
  assign done = run && !no_done && cu_cnt != 4'd0 && cu_cnt == need;

  task clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 9'h000;
  endtask

  task pulse_start(input logic [5:0] len);
    prog_len = len;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task test_reset;
    checks++;
    if (run !== 1'b0 || din !== 9'h000 || busy !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs run=%b din=%h busy=%b rd=%b addr=%0d expected all zero", run, din, busy, mem_rd, mem_addr);
    end
    checks++;
    if (halted !== 1'b0 || error !== 1'b0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_status halted=%b error=%b count=%0d expected 0 0 0", halted, error, instr_count);
    end
  endtask

  task test_mvi_prog;
    int done_c;
    done_c = 0;
    clear_mem;
    mem[0] = 9'h100; mem[1] = 9'h005; mem[2] = 9'h048; mem[3] = 9'h000;
    pulse_start(6'd4);
    for (int c = 1; c <= 17; c++) begin
      if (done === 1'b1 && done_c == 0) done_c = c;
      if (c == 1) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin errors++; $display("FAIL mvi_rd_i rd=%b addr=%0d expected 1 0", mem_rd, mem_addr); end
      end
      if (c == 3) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 5'd1) begin errors++; $display("FAIL mvi_rd_d rd=%b addr=%0d expected 1 1", mem_rd, mem_addr); end
      end
      if (c == 5) begin
        checks++;
        if (run !== 1'b1 || din !== 9'h100) begin errors++; $display("FAIL mvi_exec0 run=%b din=%h expected 1 100", run, din); end
      end
      if (c == 6) begin
        checks++;
        if (run !== 1'b1 || din !== 9'h005) begin errors++; $display("FAIL mvi_imm run=%b din=%h expected 1 005", run, din); end
      end
      if (c == 10) begin
        checks++;
        if (run !== 1'b1 || din !== 9'h048) begin errors++; $display("FAIL mv_exec0 run=%b din=%h expected 1 048", run, din); end
      end
      if (c == 17) begin
        checks++;
        if (busy !== 1'b0 || halted !== 1'b1 || error !== 1'b0 || instr_count !== 8'd3) begin
          errors++;
          $display("FAIL mvi_prog_end busy=%b halted=%b error=%b count=%0d expected 0 1 0 3", busy, halted, error, instr_count);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (done_c != 7) begin errors++; $display("FAIL mvi_latency done_cycle=%0d expected 7", done_c); end
  endtask

  task test_add;
    int run_n, done_c;
    run_n = 0; done_c = 0;
    clear_mem;
    mem[0] = 9'h093;
    pulse_start(6'd1);
    for (int c = 1; c <= 10; c++) begin
      if (run === 1'b1) run_n++;
      if (done === 1'b1 && done_c == 0) done_c = c;
      if (c == 6) begin
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_not_yet_halted halted=%b busy=%b expected 0 1", halted, busy); end
      end
      if (c == 7) begin
        checks++;
        if (halted !== 1'b1 || run !== 1'b0 || mem_addr !== 5'd1 || instr_count !== 8'd1) begin
          errors++;
          $display("FAIL add_end halted=%b run=%b pc=%0d count=%0d expected 1 0 1 1", halted, run, mem_addr, instr_count);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (run_n != 4 || done_c != 6) begin errors++; $display("FAIL add_run_len run_cycles=%0d done_cycle=%0d expected 4 6", run_n, done_c); end
  endtask

  task test_timeout;
    int run_n;
    run_n = 0;
    clear_mem;
    no_done = 1'b1;
    pulse_start(6'd1);
    for (int c = 1; c <= 14; c++) begin
      if (run === 1'b1) run_n++;
      if (c == 11) begin
        checks++;
        if (run !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL timeout_early run=%b error=%b expected 1 0", run, error); end
      end
      if (c == 12) begin
        checks++;
        if (error !== 1'b1 || run !== 1'b0 || busy !== 1'b0 || instr_count !== 8'd0) begin
          errors++;
          $display("FAIL timeout_flag error=%b run=%b busy=%b count=%0d expected 1 0 0 0", error, run, busy, instr_count);
        end
      end
      @(negedge clock);
    end
    no_done = 1'b0;
    checks++;
    if (run_n != 9) begin errors++; $display("FAIL timeout_run_len run_cycles=%0d expected 9", run_n); end
  endtask

  task test_bad_opcode;
    int run_n, rd_n;
    run_n = 0; rd_n = 0;
    clear_mem;
    mem[0] = 9'h1C0;
    pulse_start(6'd4);
    for (int c = 1; c <= 5; c++) begin
      if (run === 1'b1) run_n++;
      if (c == 2) begin
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL bad_op_early error=%b expected 0", error); end
      end
      if (c == 3) begin
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bad_op_flag error=%b busy=%b expected 1 0", error, busy); end
      end
      @(negedge clock);
    end
    mem[0] = 9'h100;
    pulse_start(6'd1);
    for (int c = 1; c <= 5; c++) begin
      if (run === 1'b1) run_n++;
      if (mem_rd === 1'b1) rd_n++;
      if (c == 3) begin
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
          errors++;
          $display("FAIL mvi_trunc error=%b busy=%b halted=%b expected 1 0 0", error, busy, halted);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (run_n != 0 || rd_n != 1) begin errors++; $display("FAIL no_issue run_cycles=%0d reads=%0d expected 0 1", run_n, rd_n); end
  endtask

  task test_stop;
    int done_n, rd_after;
    done_n = 0; rd_after = 0;
    clear_mem;
    mem[0] = 9'h093; mem[1] = 9'h093; mem[2] = 9'h093;
    pulse_start(6'd3);
    for (int c = 1; c <= 12; c++) begin
      stop = c == 4;
      if (done === 1'b1) done_n++;
      if (c > 6 && mem_rd === 1'b1) rd_after++;
      if (c == 7) begin
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || instr_count !== 8'd1 || mem_addr !== 5'd1) begin
          errors++;
          $display("FAIL stop_halt halted=%b busy=%b count=%0d pc=%0d expected 1 0 1 1", halted, busy, instr_count, mem_addr);
        end
      end
      @(negedge clock);
    end
    stop = 1'b0;
    checks++;
    if (done_n != 1 || rd_after != 0) begin errors++; $display("FAIL stop_no_more dones=%0d reads_after=%0d expected 1 0", done_n, rd_after); end
  endtask

  task test_start_stop_same;
    clear_mem;
    prog_len = 6'd2;
    @(negedge clock);
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    repeat (12) @(negedge clock);
    checks++;
    if (instr_count !== 8'd2 || halted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_wins count=%0d halted=%b busy=%b expected 2 1 0", instr_count, halted, busy);
    end
    pulse_start(6'd0);
    checks++;
    if (busy !== 1'b0 || halted !== 1'b1 || mem_rd !== 1'b0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL empty_prog busy=%b halted=%b rd=%b count=%0d expected 0 1 0 0", busy, halted, mem_rd, instr_count);
    end
  endtask

  task test_async_reset;
    clear_mem;
    mem[0] = 9'h093;
    pulse_start(6'd1);
    repeat (3) @(negedge clock);
    checks++;
    if (run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre run=%b busy=%b expected 1 1", run, busy); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0 || din !== 9'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate run=%b din=%h busy=%b expected 0 000 0", run, din, busy);
    end
    @(negedge clock);
    resetn = 1'b1;
    mem[0] = 9'h000;
    pulse_start(6'd1);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin errors++; $display("FAIL arst_restart rd=%b addr=%0d expected 1 0", mem_rd, mem_addr); end
    repeat (4) @(negedge clock);
    checks++;
    if (halted !== 1'b1 || instr_count !== 8'd1 || error !== 1'b0) begin
      errors++;
      $display("FAIL arst_rerun halted=%b count=%0d error=%b expected 1 1 0", halted, instr_count, error);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; no_done = 1'b0; prog_len = 6'd0;
    clear_mem;
    repeat (2) @(negedge clock);
    test_reset;
    resetn = 1'b1;
    test_mvi_prog;
    test_add;
    test_timeout;
    test_bad_opcode;
    test_stop;
    test_start_stop_same;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Supplies the processor datapath's instruction bus. Reads 9-bit words from a synchronous program memory and drives din and run into the control unit.
- For MVI, it prefetches the immediate word and presents it in the cycle after the opcode word.
- It waits for done before advancing, so a program runs unattended from start to halt or error.

Parameters:
- ADDR_W, 5, program memory address width.
- DATA_W, 9, instruction/data word width; matches the IR width.
- TIMEOUT, 8, maximum number of EXEC cycles without done before an error is flagged.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins execution at address 0. Ignored while busy.
- stop  in  1  single-cycle pulse; requests a halt at the next instruction boundary.
- prog_len  in  ADDR_W+1  number of words in the program. Sampled on start.
- mem_addr  out  ADDR_W  program memory address.
- mem_rd  out  1  read strobe; mem_rdata is valid in the cycle after the strobe.
- mem_rdata  in  DATA_W  program memory read data.
- din  out  DATA_W  instruction/immediate bus to the datapath.
- run  out  1  instruction-active signal to the control unit.
- done  in  1  instruction-complete signal from the control unit. Combinational, valid during the final step.
- busy  out  1  high in every state except IDLE.
- halted  out  1  sticky; the program completed normally or was stopped.
- error  out  1  sticky; timeout, undefined opcode, or truncated MVI.
- instr_count  out  8  number of instructions retired; saturates at 255.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, run=0, din=0, mem_addr=0, mem_rd=0, busy=0, halted=0, error=0, instr_count=0, stop_req=0. An active reset mid-instruction drops run immediately.
- IDLE, start=1:
  - pc=0; halted, error, instr_count cleared; prog_len latched.
  - If prog_len==0, set halted=1 and stay in IDLE.
  - Otherwise go to RD_I.
- RD_I: mem_addr=pc, mem_rd=1 for one cycle -> LAT_I.
- LAT_I: ir_buf <= mem_rdata. Decode opcode = ir_buf[8:6]:
  - Opcode 101..111: error=1 -> IDLE. Nothing is issued.
  - MVI (100) with pc+1 >= prog_len: error=1 -> IDLE (truncated immediate).
  - MVI otherwise -> RD_D.
  - Any other opcode -> EXEC0.
- RD_D: mem_addr=pc+1, mem_rd=1 -> LAT_D. LAT_D: imm_buf <= mem_rdata -> EXEC0.
- EXEC0: din=ir_buf, run=1. This is the control unit's fetch step (counter 00) -> EXEC. The watchdog is cleared here.
- EXEC:
  - run=1; din=imm_buf for MVI, else ir_buf. Held stable until done.
  - The watchdog increments each cycle.
  - done sampled 1 at a clock edge:
    - pc += 2 for MVI, else pc += 1.
    - instr_count increments (saturating at 255).
    - run=0 from the next cycle.
    - Next state is IDLE with halted=1 if the new pc >= prog_len or stop_req is set; otherwise RD_I.
  - Watchdog reaches TIMEOUT with no done: error=1, run=0 -> IDLE.
- done outside EXEC is ignored.
- stop sets stop_req in any busy state. It never aborts an instruction in flight; it takes effect only at the done boundary. stop_req is cleared on entering IDLE. stop while in IDLE does nothing.
- start while busy is ignored. start and stop in the same IDLE cycle: start wins and stop is dropped.
- Minimum cycles per instruction:
  - NOP: 4 (RD_I, LAT_I, EXEC0, EXEC).
  - MV: 5.
  - ADD/SUB: 6.
  - MVI: 7 (adds RD_D and LAT_D).
- run is low for at least two cycles between instructions (RD_I and LAT_I), which guarantees the control unit's counter clear is observed.
- All outputs are registered. busy is derived from the state register.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP=000, OP_MV=001, OP_ADD=010, OP_SUB=011, OP_MVI=100;
  - IR field positions (opcode 8:6, Rx 5:3, Ry 2:0) and DATA_W=9;
  - the feeder state encoding.
- The control unit and this block both import cpu_pkg.
- One sub-module, feeder_watchdog: a cycle counter with clear and enable inputs and a timeout output, parameterised by TIMEOUT.

Test Plan:
- Memory {MVI R0; 0x005; MV R1,R0; NOP}, prog_len=4, responder model asserts done at the correct counter step -> din shows 0x100, then 0x005; instr_count=3; halted=1; error=0; MVI takes 7 cycles from RD_I to done.
- Memory {ADD R2,R3}, prog_len=1 -> run high for exactly 4 cycles (done in the 4th); pc=1; halted=1 the cycle after done.
- Responder never asserts done, TIMEOUT=8 -> error=1 after 8 EXEC cycles; run=0; instr_count=0; busy=0.
- Word 0x1C0 (opcode 111) at address 0 -> run never asserted; error=1 two cycles after RD_I. Separately, MVI as the last word with prog_len=1 -> error=1, no issue.
- stop pulsed during EXEC of instruction 1 of 3 -> instruction 1 completes; halted=1; instr_count=1; pc=1.
- Async resetn low mid-EXEC -> run, din, and busy are 0 in the same cycle; after release, start re-runs from address 0.
